lc3_pipe_controller: RTL and testbench

LC3_PIPE_CONTROLLER -- requirements
Module: lc3_pipe_controller

---
 rtl/lc3_pipe_controller.sv | 141 ++++++++++++++
 tb/tb_lc3_pipe_controller.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_pipe_controller.sv
// Pipeline stage controller for a five-stage LC-3: fill, run, memory stalls and branch flush.
// Optional stall-cycle performance counter enabled by defining LC3_CTRL_PERF_EN.
module lc3_pipe_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IR,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic [1:0]  mem_state
`ifdef LC3_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic [2:0] {
    FILL,
    RUN,
    MEM_IND,
    MEM_RD,
    MEM_WR,
    FLUSH
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;

  state_t     state, state_next;
  logic [2:0] cnt, cnt_next;
  logic [3:0] opcode;
  logic       ir_low_unused;

  assign opcode        = IR[15:12];
  assign ir_low_unused = ^IR[8:0];

  // cnt counts fill steps in FILL and flush cycles in FLUSH
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FILL;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    enable_updatePC  = 1'b0;
    enable_fetch     = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    br_taken         = 1'b0;
    mem_state        = 2'b11;
    case (state)
      FILL: begin
        enable_updatePC  = (cnt >= 3'd1);
        enable_fetch     = (cnt >= 3'd1);
        enable_decode    = (cnt >= 3'd2);
        enable_execute   = (cnt >= 3'd3);
        enable_writeback = (cnt >= 3'd4);
        if (cnt == 3'd4) state_next = RUN;
        else             cnt_next   = cnt + 3'd1;
      end
      RUN: begin
        enable_updatePC  = complete_instr;
        enable_fetch     = complete_instr;
        enable_decode    = complete_instr;
        enable_execute   = complete_instr;
        enable_writeback = complete_instr;
        // memory opcodes and control transfers are disjoint, so memory wins trivially
        if (complete_instr) begin
          case (opcode)
            OP_LD, OP_LDR:   state_next = MEM_RD;
            OP_ST, OP_STR:   state_next = MEM_WR;
            OP_LDI, OP_STI:  state_next = MEM_IND;
            OP_BR: begin
              br_taken = |(IR[11:9] & psr);
              if (br_taken) begin
                state_next = FLUSH;
                cnt_next   = 3'd0;
              end
            end
            OP_JMP: begin
              br_taken   = 1'b1;
              state_next = FLUSH;
              cnt_next   = 3'd0;
            end
            default: state_next = RUN;
          endcase
        end
      end
      MEM_IND: begin
        mem_state = 2'b01;
        if (complete_data) state_next = (opcode == OP_STI) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_state        = 2'b00;
        enable_writeback = complete_data;
        if (complete_data) state_next = RUN;
      end
      MEM_WR: begin
        mem_state = 2'b10;
        if (complete_data) state_next = RUN;
      end
      FLUSH: begin
        enable_updatePC = 1'b1;
        enable_fetch    = 1'b1;
        if (cnt == 3'd1) state_next = RUN;
        else             cnt_next   = cnt + 3'd1;
      end
      default: state_next = FILL;
    endcase
  end

`ifdef LC3_CTRL_PERF_EN
  // counts fetch-stalled cycles once the pipe has filled, saturating at all ones
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_cycles <= 16'd0;
    else if ((state != FILL) && !enable_fetch && (stall_cycles != 16'hFFFF))
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Self-checking bench for lc3_pipe_controller: directed scenarios plus a randomized
// instruction stream checked against a transaction-level model of the pipeline rules.
module tb_lc3_pipe_controller;

  logic        clock;
  logic        reset;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] IR;
  logic [2:0]  psr;
  logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
  logic        br_taken;
  logic [1:0]  mem_state;
`ifdef LC3_CTRL_PERF_EN
  logic [15:0] stall_cycles;
`endif

  int vectors = 0;
  int miscompares = 0;

  lc3_pipe_controller dut (
    .clock(clock),
    .reset(reset),
    .complete_instr(complete_instr),
    .complete_data(complete_data),
    .IR(IR),
    .psr(psr),
    .enable_updatePC(enable_updatePC),
    .enable_fetch(enable_fetch),
    .enable_decode(enable_decode),
    .enable_execute(enable_execute),
    .enable_writeback(enable_writeback),
    .br_taken(br_taken),
    .mem_state(mem_state)
`ifdef LC3_CTRL_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [7:0] obs();
    return {enable_updatePC, enable_fetch, enable_decode, enable_execute,
            enable_writeback, br_taken, mem_state};
  endfunction

  function automatic logic [7:0] mk(input bit u, input bit f, input bit d, input bit e,
                                    input bit w, input bit b, input logic [1:0] m);
    return {u, f, d, e, w, b, m};
  endfunction

  // inputs change 1ns after the rising edge; outputs are sampled on the falling edge
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    IR = 16'hC000; complete_instr = 1'b1; complete_data = 1'b1; psr = 3'b111;
    #1;
    if (obs() !== mk(0,0,0,0,0,0,2'b11)) begin
      miscompares++;
      $display("FAIL reset_state: got %b want %b", obs(), mk(0,0,0,0,0,0,2'b11));
    end
    vectors++;
    next_cycle();
  endtask

  // releases reset and expects stage k enabled from the k-th cycle after release
  task automatic test_fill(input string tag);
    logic [7:0] exp;
    IR = 16'h1000; complete_instr = 1'b1; complete_data = 1'b0; psr = 3'b000;
    reset = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      exp = mk(k >= 1, k >= 1, k >= 2, k >= 3, k >= 4, 0, 2'b11);
      @(negedge clock);
      if (obs() !== exp) begin
        miscompares++;
        $display("FAIL %s_fill c%0d: got %b want %b", tag, k, obs(), exp);
      end
      vectors++;
      next_cycle();
    end
    @(negedge clock);
    if (obs() !== mk(1,1,1,1,1,0,2'b11)) begin
      miscompares++;
      $display("FAIL %s_run_entry: got %b want %b", tag, obs(), mk(1,1,1,1,1,0,2'b11));
    end
    vectors++;
    next_cycle();
  endtask

  task automatic test_stall_and_ignore();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      complete_instr = i[0];
      complete_data  = 1'b1;
      IR = 16'h1000;
      exp = i[0] ? mk(1,1,1,1,1,0,2'b11) : mk(0,0,0,0,0,0,2'b11);
      @(negedge clock);
      if (obs() !== exp) begin
        miscompares++;
        $display("FAIL stall_ignore c%0d: got %b want %b", i, obs(), exp);
      end
      vectors++;
      next_cycle();
    end
    complete_data = 1'b0;
  endtask

  task automatic test_load();
    logic [7:0] exp;
    IR = 16'h2C05; complete_instr = 1'b1; complete_data = 1'b0;
    @(negedge clock);
    if (obs() !== mk(1,1,1,1,1,0,2'b11)) begin
      miscompares++;
      $display("FAIL load_issue: got %b want %b", obs(), mk(1,1,1,1,1,0,2'b11));
    end
    vectors++;
    next_cycle();
    for (int i = 1; i <= 3; i++) begin
      complete_data = (i == 3);
      exp = mk(0,0,0,0, i == 3, 0, 2'b00);
      @(negedge clock);
      if (obs() !== exp) begin
        miscompares++;
        $display("FAIL load_wait c%0d: got %b want %b", i, obs(), exp);
      end
      vectors++;
      next_cycle();
    end
    IR = 16'h1000; complete_data = 1'b0;
    @(negedge clock);
    if (obs() !== mk(1,1,1,1,1,0,2'b11)) begin
      miscompares++;
      $display("FAIL load_return: got %b want %b", obs(), mk(1,1,1,1,1,0,2'b11));
    end
    vectors++;
    next_cycle();
  endtask

  task automatic test_indirect();
    logic [7:0] exp;
    logic [1:0] codes [0:3];
    codes = '{2'b01, 2'b01, 2'b00, 2'b00};
    IR = 16'hAA02; complete_instr = 1'b1; complete_data = 1'b0;
    @(negedge clock);
    vectors++;
    if (obs() !== mk(1,1,1,1,1,0,2'b11)) begin
      miscompares++;
      $display("FAIL ldi_issue: got %b want %b", obs(), mk(1,1,1,1,1,0,2'b11));
    end
    next_cycle();
    for (int i = 1; i <= 4; i++) begin
      complete_data  = (i == 2 || i == 4);
      complete_instr = i[0];
      exp = mk(0,0,0,0, i == 4, 0, codes[i-1]);
      @(negedge clock);
      if (obs() !== exp) begin
        miscompares++;
        $display("FAIL ldi_wait c%0d: got %b want %b", i, obs(), exp);
      end
      vectors++;
      next_cycle();
    end
    IR = 16'h1000; complete_instr = 1'b1; complete_data = 1'b0;
    @(negedge clock);
    if (obs() !== mk(1,1,1,1,1,0,2'b11)) begin
      miscompares++;
      $display("FAIL ldi_return: got %b want %b", obs(), mk(1,1,1,1,1,0,2'b11));
    end
    vectors++;
    next_cycle();
  endtask

  task automatic test_branch();
    logic [7:0] exp;
    IR = 16'h0402; psr = 3'b001; complete_instr = 1'b1;
    @(negedge clock);
    if (obs() !== mk(1,1,1,1,1,0,2'b11)) begin
      miscompares++;
      $display("FAIL brz_not_taken: got %b want %b", obs(), mk(1,1,1,1,1,0,2'b11));
    end
    vectors++;
    next_cycle();
    psr = 3'b010;
    @(negedge clock);
    if (obs() !== mk(1,1,1,1,1,1,2'b11)) begin
      miscompares++;
      $display("FAIL brz_taken: got %b want %b", obs(), mk(1,1,1,1,1,1,2'b11));
    end
    vectors++;
    next_cycle();
    IR = 16'h1000;
    for (int i = 0; i < 3; i++) begin
      exp = (i < 2) ? mk(1,1,0,0,0,0,2'b11) : mk(1,1,1,1,1,0,2'b11);
      @(negedge clock);
      if (obs() !== exp) begin
        miscompares++;
        $display("FAIL brz_flush c%0d: got %b want %b", i, obs(), exp);
      end
      vectors++;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    IR = 16'h3000; complete_instr = 1'b1; complete_data = 1'b0;
    @(negedge clock);
    next_cycle();
    @(negedge clock);
    if (obs() !== mk(0,0,0,0,0,0,2'b10)) begin
      miscompares++;
      $display("FAIL st_wait: got %b want %b", obs(), mk(0,0,0,0,0,0,2'b10));
    end
    vectors++;
    reset = 1'b1;
    #1;
    if (obs() !== mk(0,0,0,0,0,0,2'b11)) begin
      miscompares++;
      $display("FAIL reset_mid_st: got %b want %b", obs(), mk(0,0,0,0,0,0,2'b11));
    end
    vectors++;
    next_cycle();
    test_fill("after_reset");
  endtask

  // transaction-level model: each RUN issue expands into its follow-up cycle pattern
  task automatic test_random();
    logic [3:0] ops [0:9];
    logic [3:0] op;
    logic [7:0] exp;
    logic [1:0] code;
    bit ci, taken, is_read, is_write, is_ind;
    int lat;
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB, 4'hC};
    for (int t = 0; t < 80; t++) begin
      op       = ops[$urandom_range(0, 9)];
      IR       = {op, 12'($urandom)};
      psr      = 3'($urandom_range(1, 7));
      ci       = ($urandom_range(0, 3) != 0);
      complete_instr = ci;
      complete_data  = 1'($urandom);
      is_read  = (op == 4'h2 || op == 4'h6 || op == 4'hA);
      is_write = (op == 4'h3 || op == 4'h7 || op == 4'hB);
      is_ind   = (op == 4'hA || op == 4'hB);
      taken    = ci && ((op == 4'h0 && ((IR[11:9] & psr) != 3'b000)) || op == 4'hC);
      exp = ci ? mk(1,1,1,1,1,taken,2'b11) : mk(0,0,0,0,0,0,2'b11);
      @(negedge clock);
      if (obs() !== exp) begin
        miscompares++;
        $display("FAIL rand_issue t%0d IR=%h psr=%b: got %b want %b", t, IR, psr, obs(), exp);
      end
      vectors++;
      next_cycle();
      if (ci && taken) begin
        for (int i = 0; i < 2; i++) begin
          complete_instr = 1'($urandom);
          @(negedge clock);
          if (obs() !== mk(1,1,0,0,0,0,2'b11)) begin
            miscompares++;
            $display("FAIL rand_flush t%0d c%0d: got %b want %b", t, i, obs(), mk(1,1,0,0,0,0,2'b11));
          end
          vectors++;
          next_cycle();
        end
      end
      if (ci && (is_read || is_write)) begin
        for (int ph = (is_ind ? 0 : 1); ph <= 1; ph++) begin
          code = (ph == 0) ? 2'b01 : (is_read ? 2'b00 : 2'b10);
          lat  = $urandom_range(1, 3);
          for (int i = 0; i < lat; i++) begin
            complete_data  = (i == lat - 1);
            complete_instr = 1'($urandom);
            psr = 3'($urandom);
            exp = mk(0,0,0,0, (ph == 1) && is_read && (i == lat - 1), 0, code);
            @(negedge clock);
            if (obs() !== exp) begin
              miscompares++;
              $display("FAIL rand_mem t%0d ph%0d c%0d IR=%h: got %b want %b", t, ph, i, IR, obs(), exp);
            end
            vectors++;
            next_cycle();
          end
        end
      end
    end
    complete_data = 1'b0;
  endtask

`ifdef LC3_CTRL_PERF_EN
  task automatic test_perf();
    reset = 1'b1;
    next_cycle();
    test_fill("perf");
    complete_instr = 1'b0;
    repeat (5) next_cycle();
    if (stall_cycles !== 16'd5) begin
      miscompares++;
      $display("FAIL perf_count: got %0d want 5", stall_cycles);
    end
    vectors++;
    repeat (65535) next_cycle();
    if (stall_cycles !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL perf_saturate: got %h want ffff", stall_cycles);
    end
    vectors++;
    complete_instr = 1'b1;
  endtask
`endif

  initial begin
    reset = 1'b1; complete_instr = 1'b0; complete_data = 1'b0; IR = 16'h0000; psr = 3'b000;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_fill("initial");
    test_stall_and_ignore();
    test_load();
    test_indirect();
    test_branch();
    test_reset_mid();
    test_random();
`ifdef LC3_CTRL_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
